i2c_target: RTL and testbench
=============================

Name: i2c_target

Overview:
I2C target (slave) endpoint: the responder on the far end of the bus that our I2C transceiver and arbiter initiate transactions to. Samples the open-drain SCL/SDA pins, detects START/STOP, matches a 7-bit address, and moves bytes to and from a local byte-stream interface. Used for on-board test targets and for FPGA-as-peripheral designs. No clock stretching.

Parameters:
TARGET_ADDR, 7'h50, 7-bit bus address this block responds to.

Ports:
clk  input  1  system clock; must be at least 16x SCL frequency.
rst_n  input  1  asynchronous active-low reset.
scl_in  input  1  raw SCL pin value (asynchronous).
sda_in  input  1  raw SDA pin value (asynchronous).
sda_oe  output  1  1 = pull SDA low; 0 = release.
addressed  output  1  pulse: address matched and ACKed.
rd_mode  output  1  R/W bit of the current addressed transaction, valid while busy.
rx_valid  output  1  pulse: rx_data holds a newly received write byte.
rx_data  output  8  last received write byte.
tx_req  output  1  pulse: supply the next read byte on tx_data.
tx_data  input  8  read byte; sampled at the SCL falling edge following tx_req.
tx_nack  output  1  pulse: host NACKed a read byte (end of read burst).
stop  output  1  pulse: STOP detected while busy.
busy  output  1  high from address match until STOP, repeated START or mismatch.

Behaviour:
- Reset values: sda_oe=0, all pulses=0, rx_data=0, rd_mode=0, busy=0, FSM=IDLE. Asserting rst_n mid-transfer releases SDA immediately (asynchronous).
- Input conditioning: each pin passes through a 2-FF synchronizer plus one history FF; edges are detected on synchronized values, so pin-to-event latency is 3 clk.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high. Both are detected in every state and take priority over bit sampling in the same clk.
- START (including a repeated START) -> ADDR, bit count 0, busy=0, sda_oe=0. STOP -> IDLE, sda_oe=0, and pulse stop if busy was 1.
- Data is sampled on the synchronized SCL rising edge. sda_oe changes only 1 clk after a synchronized SCL falling edge, which guarantees SDA hold time.
- FSM states: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE.
- ADDR: shift 8 bits MSB first.
  - If bits[7:1]==TARGET_ADDR: go to ADDR_ACK, latch rd_mode=bit0.
  - Otherwise go to IGNORE, which waits for START/STOP with SDA released. General call 7'h00 goes to IGNORE.
- ADDR_ACK: drive sda_oe=1 for one SCL period (falling edge to falling edge). Pulse addressed and set busy=1 on the rising edge of the ACK slot.
  - If rd_mode=1, also pulse tx_req on that clk. Load tx_data at the next falling edge, then go to READ.
  - If rd_mode=0, go to WRITE at the falling edge.
- WRITE: shift 8 bits. On the 8th rising edge, update rx_data and pulse rx_valid 1 clk later, then go to WRITE_ACK. Every byte is ACKed. WRITE_ACK then returns to WRITE.
- READ: drive shift-register MSB first. sda_oe = ~bit, updated after each falling edge. After the 8th bit's falling edge, release SDA and go to READ_ACK.
- READ_ACK: sample host SDA on the rising edge.
  - 0 (ACK): pulse tx_req, load tx_data at the falling edge, go to READ.
  - 1 (NACK): pulse tx_nack, go to IGNORE with SDA released until STOP/START. busy stays 1 until then.
- The tx_data source must respond within the SCL high time minus 3 clk.
- A START or STOP mid-byte discards the partial byte. No rx_valid is generated for it.
- Bit counter is 3 bits and wraps 7->0 at each byte boundary. No other arithmetic.

Test Plan:
- Write 0x50 addr + bytes 0xA5, 0x3C + STOP -> addressed x1, sda_oe low in each ACK slot, rx_valid x2 with rx_data 0xA5 then 0x3C, stop x1, busy 0 afterwards.
- Addr 0x51 (mismatch), then write 0xFF -> no ACK, sda_oe never asserted, no pulses, busy stays 0.
- Read from 0x50, tx_data 0x81 then 0x7E, host ACK then NACK -> SDA pattern 10000001, 01111110; tx_req x2; tx_nack x1; SDA released through STOP.
- Write 1 byte, repeated START, read 1 byte -> rd_mode goes 0 then 1, addressed x2, no stop pulse between.
- START mid-data-byte after 4 bits -> partial byte dropped (no rx_valid), FSM re-enters ADDR, next addr 0x50 ACKed.
- rst_n low while driving a read 0 bit -> sda_oe drops to 0 within the same clk; all outputs at reset values.

Source files
------------

// File: rtl/i2c_target.sv
// i2c_target: I2C target (slave) endpoint with a 7-bit address and no clock stretching.
// Samples raw SCL/SDA through 2-FF synchronizers and detects START/STOP.
// Matches TARGET_ADDR, then moves bytes to and from a local byte-stream interface.
// Ports:
//   clk, rst_n           system clock (>= 16x SCL), asynchronous active-low reset
//   scl_in, sda_in       raw bus pin values
//   sda_oe               1 = pull SDA low
//   addressed            pulse: address matched and ACKed
//   rd_mode              R/W bit of the current transaction
//   rx_valid, rx_data    received write byte (rx_data updates 1 clk before the pulse)
//   tx_req, tx_data      request/supply of the next read byte
//   tx_nack              pulse: host NACKed a read byte
//   stop                 pulse: STOP seen while busy
//   busy                 addressed transaction in progress
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       addressed,
  output logic       rd_mode,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       tx_nack,
  output logic       stop,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_IGNORE
  } state_e;

  state_e      state_q, state_d;
  logic        scl_s1_q, scl_s2_q, scl_h_q;
  logic        sda_s1_q, sda_s2_q, sda_h_q;
  logic [2:0]  cnt_q, cnt_d;
  logic [6:0]  sh_q, sh_d;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;
  logic        rd_q, rd_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_load_q, rx_load_d;
  logic        rx_valid_q;
  logic        addressed_q, addressed_d;
  logic        tx_req_q, tx_req_d;
  logic        tx_nack_q, tx_nack_d;
  logic        stop_q, stop_d;

  logic        scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]  byte_in;

  assign scl_rise  = scl_s2_q & ~scl_h_q;
  assign scl_fall  = ~scl_s2_q & scl_h_q;
  assign start_det = scl_s2_q & sda_h_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & ~sda_h_q & sda_s2_q;
  // Receive shifter only needs 7 bits: the 8th comes straight from the pin.
  assign byte_in   = {sh_q, sda_s2_q};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    oe_d        = oe_q;
    busy_d      = busy_q;
    rd_d        = rd_q;
    rx_data_d   = rx_data_q;
    rx_load_d   = 1'b0;
    addressed_d = 1'b0;
    tx_req_d    = 1'b0;
    tx_nack_d   = 1'b0;
    stop_d      = 1'b0;
    if (start_det) begin
      state_d = S_ADDR;
      cnt_d   = '0;
      busy_d  = 1'b0;
      oe_d    = 1'b0;
    end else if (stop_det) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
      stop_d  = busy_q;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_ADDR: if (scl_rise) begin
          sh_d  = byte_in[6:0];
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (byte_in[7:1] == TARGET_ADDR && byte_in[7:1] != 7'h00) begin
              state_d = S_ADDR_ACK;
              rd_d    = byte_in[0];
            end else begin
              state_d = S_IGNORE;
            end
          end
        end
        // ACK slots: oe_q doubles as the phase flag (first fall drives, second fall ends).
        S_ADDR_ACK: begin
          if (scl_rise && oe_q) begin
            addressed_d = 1'b1;
            busy_d      = 1'b1;
            tx_req_d    = rd_q;
          end
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else if (rd_q) begin
              sh_d    = tx_data[6:0];
              oe_d    = ~tx_data[7];
              state_d = S_READ;
            end else begin
              oe_d    = 1'b0;
              state_d = S_WRITE;
            end
          end
        end
        S_WRITE: if (scl_rise) begin
          sh_d  = byte_in[6:0];
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            rx_data_d = byte_in;
            rx_load_d = 1'b1;
            state_d   = S_WRITE_ACK;
          end
        end
        S_WRITE_ACK: if (scl_fall) begin
          if (!oe_q) begin
            oe_d = 1'b1;
          end else begin
            oe_d    = 1'b0;
            state_d = S_WRITE;
          end
        end
        S_READ: if (scl_fall) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            oe_d    = 1'b0;
            state_d = S_READ_ACK;
          end else begin
            oe_d = ~sh_q[6];
            sh_d = {sh_q[5:0], 1'b0};
          end
        end
        S_READ_ACK: begin
          if (scl_rise) begin
            if (!sda_s2_q) begin
              tx_req_d = 1'b1;
            end else begin
              tx_nack_d = 1'b1;
              state_d   = S_IGNORE;
            end
          end
          if (scl_fall) begin
            sh_d    = tx_data[6:0];
            oe_d    = ~tx_data[7];
            state_d = S_READ;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1_q    <= 1'b1;
      scl_s2_q    <= 1'b1;
      scl_h_q     <= 1'b1;
      sda_s1_q    <= 1'b1;
      sda_s2_q    <= 1'b1;
      sda_h_q     <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      rd_q        <= 1'b0;
      rx_data_q   <= '0;
      rx_load_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      addressed_q <= 1'b0;
      tx_req_q    <= 1'b0;
      tx_nack_q   <= 1'b0;
      stop_q      <= 1'b0;
    end else begin
      {scl_h_q, scl_s2_q, scl_s1_q} <= {scl_s2_q, scl_s1_q, scl_in};
      {sda_h_q, sda_s2_q, sda_s1_q} <= {sda_s2_q, sda_s1_q, sda_in};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      rd_q        <= rd_d;
      rx_data_q   <= rx_data_d;
      rx_load_q   <= rx_load_d;
      rx_valid_q  <= rx_load_q;
      addressed_q <= addressed_d;
      tx_req_q    <= tx_req_d;
      tx_nack_q   <= tx_nack_d;
      stop_q      <= stop_d;
    end
  end

  assign sda_oe    = oe_q;
  assign addressed = addressed_q;
  assign rd_mode   = rd_q;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign tx_req    = tx_req_q;
  assign tx_nack   = tx_nack_q;
  assign stop      = stop_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Testbench for i2c_target: bit-banged I2C host, open-drain bus, table of transactions.
module tb_i2c_target;
  localparam int Q = 8;  // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       host_sda = 1'b1;
  logic       sda_line;
  logic       sda_oe, addressed, rd_mode, rx_valid, tx_req, tx_nack, stop, busy;
  logic [7:0] rx_data;
  logic [7:0] tx_data = 8'h00;

  assign sda_line = host_sda & ~sda_oe;

  i2c_target #(.TARGET_ADDR(7'h50)) dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl), .sda_in(sda_line),
    .sda_oe(sda_oe), .addressed(addressed), .rd_mode(rd_mode),
    .rx_valid(rx_valid), .rx_data(rx_data), .tx_req(tx_req), .tx_data(tx_data),
    .tx_nack(tx_nack), .stop(stop), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int n_addr = 0, n_rxv = 0, n_txr = 0, n_nack = 0, n_stop = 0;
  bit oe_seen = 0;
  logic [7:0] rx_got[$];
  logic [7:0] txq[$];

  always @(negedge clk) begin
    if (addressed) n_addr++;
    if (rx_valid) begin n_rxv++; rx_got.push_back(rx_data); end
    if (tx_nack) n_nack++;
    if (stop) n_stop++;
    if (sda_oe) oe_seen = 1;
  end

  // Local read-data source: answers tx_req half a clk later.
  initial forever begin
    @(negedge clk);
    if (tx_req) begin
      n_txr++;
      if (txq.size() > 0) tx_data = txq.pop_front();
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sbit(input logic b, output logic r);
    host_sda = b; wq(Q);
    scl = 1'b1;   wq(Q);
    r = sda_line; wq(Q);
    scl = 1'b0;   wq(Q);
  endtask

  task automatic do_start;
    host_sda = 1'b1; wq(Q);
    scl = 1'b1;      wq(Q);
    host_sda = 1'b0; wq(Q);
    scl = 1'b0;      wq(Q);
  endtask

  task automatic do_stop;
    host_sda = 1'b0; wq(Q);
    scl = 1'b1;      wq(Q);
    host_sda = 1'b1; wq(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) sbit(b[i], r);
    sbit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) begin sbit(1'b1, r); b[i] = r; end
    sbit(nack, r);
  endtask

  // Reference: a target answers only its own non-zero address.
  function automatic bit model_match(input logic [6:0] a);
    return (a == 7'h50) && (a != 7'h00);
  endfunction

  typedef struct {
    logic [6:0]      addr;
    logic            rw;
    int              n;
    logic [3:0][7:0] d;
    bit              exp_ack;
  } txn_t;

  task automatic run_txn(input txn_t t);
    int a0, r0, q0, k0, s0;
    logic ack;
    logic [7:0] b;
    a0 = n_addr; r0 = n_rxv; q0 = n_txr; k0 = n_nack; s0 = n_stop;
    rx_got.delete(); txq.delete(); oe_seen = 0;
    if (t.rw && t.exp_ack) for (int i = 0; i < t.n; i++) txq.push_back(t.d[i]);
    do_start;
    send_byte({t.addr, t.rw}, ack);
    check("addr_ack_line", ack, t.exp_ack ? 0 : 1);
    for (int i = 0; i < t.n; i++) begin
      if (!t.rw) begin
        send_byte(t.d[i], ack);
        check("wr_ack_line", ack, t.exp_ack ? 0 : 1);
      end else begin
        recv_byte(i == t.n - 1, b);
        check("rd_byte", b, t.exp_ack ? t.d[i] : 8'hFF);
      end
    end
    do_stop;
    wq(8);
    check("addressed_cnt", n_addr - a0, t.exp_ack ? 1 : 0);
    check("rx_valid_cnt", n_rxv - r0, (t.exp_ack && !t.rw) ? t.n : 0);
    for (int i = 0; i < rx_got.size() && i < t.n; i++) check("rx_data", rx_got[i], t.d[i]);
    check("tx_req_cnt", n_txr - q0, (t.exp_ack && t.rw) ? t.n : 0);
    check("tx_nack_cnt", n_nack - k0, (t.exp_ack && t.rw) ? 1 : 0);
    check("stop_cnt", n_stop - s0, t.exp_ack ? 1 : 0);
    check("busy_after", busy, 0);
    check("sda_oe_seen", oe_seen, t.exp_ack);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  txn_t tv[12];
  int a0, r0, s0;
  logic ack;
  logic [7:0] b;
  logic r;

  initial begin
    tv[0] = '{addr: 7'h50, rw: 1'b0, n: 2, d: {8'h00, 8'h00, 8'h3C, 8'hA5}, exp_ack: 1'b1};
    tv[1] = '{addr: 7'h51, rw: 1'b0, n: 1, d: {8'h00, 8'h00, 8'h00, 8'hFF}, exp_ack: 1'b0};
    tv[2] = '{addr: 7'h50, rw: 1'b1, n: 2, d: {8'h00, 8'h00, 8'h7E, 8'h81}, exp_ack: 1'b1};
    tv[3] = '{addr: 7'h00, rw: 1'b0, n: 1, d: {8'h00, 8'h00, 8'h00, 8'h12}, exp_ack: 1'b0};
    for (int k = 4; k < 12; k++) begin
      tv[k].addr = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(0, 127)) : 7'h50;
      tv[k].rw   = 1'($urandom_range(0, 1));
      tv[k].n    = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) tv[k].d[i] = 8'($urandom);
      tv[k].exp_ack = model_match(tv[k].addr);
    end

    wq(4);
    rst_n = 1'b1;
    wq(8);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_mode", rd_mode, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_pulses", {addressed, rx_valid, tx_req, tx_nack, stop}, 0);

    for (int k = 0; k < 12; k++) run_txn(tv[k]);

    // Write one byte, repeated START, then read one byte.
    a0 = n_addr; r0 = n_rxv; s0 = n_stop; rx_got.delete(); txq.delete();
    txq.push_back(8'hC3);
    do_start;
    send_byte({7'h50, 1'b0}, ack);
    check("sr_w_ack", ack, 0);
    check("sr_rd_mode_w", rd_mode, 0);
    check("sr_busy_w", busy, 1);
    send_byte(8'h5A, ack);
    do_start;
    check("sr_busy_cleared", busy, 0);
    send_byte({7'h50, 1'b1}, ack);
    check("sr_r_ack", ack, 0);
    check("sr_rd_mode_r", rd_mode, 1);
    check("sr_no_stop_between", n_stop - s0, 0);
    recv_byte(1'b1, b);
    check("sr_rd_byte", b, 8'hC3);
    do_stop;
    wq(8);
    check("sr_addressed_cnt", n_addr - a0, 2);
    check("sr_stop_cnt", n_stop - s0, 1);
    check("sr_rx_cnt", n_rxv - r0, 1);
    if (rx_got.size() > 0) check("sr_rx_data", rx_got[0], 8'h5A);

    // START after four data bits drops the partial byte.
    a0 = n_addr; r0 = n_rxv; rx_got.delete();
    do_start;
    send_byte({7'h50, 1'b0}, ack);
    sbit(1'b1, r); sbit(1'b0, r); sbit(1'b1, r); sbit(1'b1, r);
    do_start;
    check("mid_rx_cnt_after_start", n_rxv - r0, 0);
    send_byte({7'h50, 1'b0}, ack);
    check("mid_readdr_ack", ack, 0);
    send_byte(8'h99, ack);
    do_stop;
    wq(8);
    check("mid_addressed_cnt", n_addr - a0, 2);
    check("mid_rx_cnt", n_rxv - r0, 1);
    if (rx_got.size() > 0) check("mid_rx_data", rx_got[0], 8'h99);

    // Reset while driving a 0 read bit releases SDA asynchronously.
    txq.delete();
    txq.push_back(8'h00);
    do_start;
    send_byte({7'h50, 1'b1}, ack);
    check("rr_addr_ack", ack, 0);
    check("rr_drive_zero", sda_oe, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rr_sda_oe_async", sda_oe, 0);
    check("rr_busy", busy, 0);
    check("rr_rd_mode", rd_mode, 0);
    check("rr_rx_data", rx_data, 0);
    check("rr_pulses", {addressed, rx_valid, tx_req, tx_nack, stop}, 0);
    wq(3);
    rst_n = 1'b1;
    scl = 1'b1; host_sda = 1'b1;
    wq(Q);
    check("rr_idle_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
